issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  Parametrised successor to the fixed 64-entry RS. Holds renamed µops between rename/dispatch and NUM_FU FUs.
//  Snoops NUM_WAKEUP result broadcasts and issues up to NUM_FU ready µops per cycle, oldest-first, to any ready FU.
//  FU is bound at issue time, not at dispatch. Adds back-pressure (dispatch_ready), flush, and occupancy count.
// PARAMETERS
//  RS_DEPTH    16  entries (power of 2 not required, >=2)
//  NUM_FU       3  issue ports / functional units
//  NUM_WAKEUP   4  wakeup broadcast ports
//  TAG_W        6  physical register tag width
//  DATA_W      32  operand / immediate width
//  ROB_W        6  ROB index width
//  OP_W         4  ALU control width
// PORTS
//  clk             in   1                   rising-edge clock
//  reset           in   1                   sync active-high reset
//  flush           in   1                   drop all entries (mispredict/exception)
//  dispatch_valid  in   1                   µop present this cycle
//  dispatch_ready  out  1                   queue can accept (count < RS_DEPTH)
//  disp_rd_tag     in   TAG_W               destination tag
//  disp_rs1_tag    in   TAG_W               src1 tag
//  disp_rs1_rdy    in   1                   src1 value valid
//  disp_rs1_val    in   DATA_W              src1 value
//  disp_rs2_tag    in   TAG_W               src2 tag
//  disp_rs2_rdy    in   1                   src2 value valid
//  disp_rs2_val    in   DATA_W              src2 value
//  disp_imm        in   DATA_W              immediate
//  disp_alu_op     in   OP_W                ALU control
//  disp_is_ls      in   1                   load/store µop
//  disp_alusrc     in   1                   use imm as operand B
//  disp_rob_num    in   ROB_W               ROB index
//  wakeup_valid    in   NUM_WAKEUP          per-port broadcast valid
//  wakeup_tag      in   NUM_WAKEUP*TAG_W    per-port tag, port p at [p*TAG_W +: TAG_W]
//  wakeup_val      in   NUM_WAKEUP*DATA_W   per-port value
//  fu_ready        in   NUM_FU              FU f can accept a µop issued at this edge
//  issue_valid     out  NUM_FU              one-cycle pulse: issue bundle f is valid
//  issue_rd_tag    out  NUM_FU*TAG_W        bundle fields, FU f at [f*W +: W]
//  issue_rs1_val   out  NUM_FU*DATA_W
//  issue_rs2_val   out  NUM_FU*DATA_W
//  issue_imm       out  NUM_FU*DATA_W
//  issue_alu_op    out  NUM_FU*OP_W
//  issue_is_ls     out  NUM_FU
//  issue_alusrc    out  NUM_FU
//  issue_rob_num   out  NUM_FU*ROB_W
//  count           out  $clog2(RS_DEPTH+1)  valid entries
// BEHAVIOUR
//  Reset: all entries invalid, age matrix cleared, count=0, issue_valid=0, all issue_* fields=0.
//  dispatch_ready = (count < RS_DEPTH). Uses registered count; same-edge issues do not free space for same-edge dispatch.
//  Dispatch: on edge with dispatch_valid & dispatch_ready & !flush, write lowest-index free entry; mark it youngest.
//   Dispatch with valid=1 and ready=0 is ignored; the source holds it.
//   No dispatch-side qualification on alu_op: every accepted µop enters.
//  Capture: a source arriving not-ready whose tag matches a valid wakeup port in the same cycle is stored ready with that
//   port's value. This is mandatory, so no broadcast is missed.
//  Wakeup: each valid entry, per source with rdy=0, compares against all ports; on match, set rdy=1 and latch value.
//   Multiple matching ports: lowest port index wins (same tag must not be broadcast twice; no check).
//  Eligible: entry valid & rs1_rdy & rs2_rdy, using state registered before this edge (see IQ_WAKEUP_BYPASS_EN).
//  Select: FUs are walked in index order 0..NUM_FU-1. Each FU with fu_ready=1 takes the oldest eligible entry not
//   already taken by a lower FU. Entry data is registered into issue bundle f, issue_valid[f]=1 for one cycle, entry freed.
//   FU with fu_ready=0 or no candidate: issue_valid[f]=0, its bundle fields hold last value.
//  Latency: µop dispatched ready at edge N is issued at edge N+1 at the earliest.
//  count_next = count + accepted_dispatch - issued_this_edge; never exceeds RS_DEPTH and never underflows.
//  Age: RS_DEPTH x RS_DEPTH age matrix. Row set on allocate; column cleared on free. Ordering survives free-slot reuse.
//  flush (priority over dispatch/issue): next edge clears all entries, count=0, issue_valid=0; that cycle's dispatch is dropped.
//  reset mid-operation behaves identically to flush and also zeroes the bundle fields.
// CONFIGURATION
//  IQ_WAKEUP_BYPASS_EN defined: an entry whose last source is woken this cycle is eligible this cycle.
//   Selected data muxes in the broadcast value (0-cycle wakeup-to-issue).
//  IQ_WAKEUP_BYPASS_EN undefined: a woken entry is eligible at the next edge (1-cycle wakeup-to-issue).
//  The capture path is unaffected either way.
// STRUCTURE
//  Package iq_pkg: entry struct/typedef (valid, is_ls, alusrc, alu_op, rd/rs tags, values, rdy bits, imm, rob_num).
//   Also holds localparams for field widths and the count width.
//  Sub-module iq_age_matrix: allocate/free vectors in; per-entry "older-than" matrix out.
//   Also provides an oldest-of(request mask) one-hot function used NUM_FU times in a cascade.
// TESTING
//  1 Reset, dispatch rs1_rdy=rs2_rdy=1, rd=5, rob=3, fu_ready=3'b111 -> next edge issue_valid=001, issue_rd_tag[0]=5.
//  2 Dispatch A (rs1 tag 9 not ready) then B (ready); wakeup tag 9 val 0xDEAD -> B issues first.
//   A issues the edge after wakeup (same edge with bypass) with rs1_val=0xDEAD.
//  3 Fill RS_DEPTH entries with fu_ready=0 -> dispatch_ready=0, count=16, extra dispatch ignored.
//   Then fu_ready=111 -> 3 oldest issue, count=13.
//  4 Dispatch with rs2 tag 12 not ready while wakeup port 3 broadcasts tag 12 val 7 same cycle -> entry issues with rs2_val=7.
//  5 Four ready entries, fu_ready=101 -> FU0 gets oldest, FU2 second oldest, issue_valid=101, count drops by 2.
//  6 Assert flush with 5 entries and dispatch_valid=1 -> next cycle count=0, issue_valid=0, no stale issue afterwards.

Source files
------------

// File: rtl/iq_pkg.sv
// Issue queue shared types: entry layout, default geometry, field widths and count width.
package iq_pkg;
  localparam int IQ_RS_DEPTH   = 16;
  localparam int IQ_NUM_FU     = 3;
  localparam int IQ_NUM_WAKEUP = 4;
  localparam int TAG_W         = 6;
  localparam int DATA_W        = 32;
  localparam int ROB_W         = 6;
  localparam int OP_W          = 4;
  localparam int IQ_CNT_W      = $clog2(IQ_RS_DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic              is_ls;
    logic              alusrc;
    logic [OP_W-1:0]   alu_op;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  rs1_tag;
    logic              rs1_rdy;
    logic [DATA_W-1:0] rs1_val;
    logic [TAG_W-1:0]  rs2_tag;
    logic              rs2_rdy;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm;
    logic [ROB_W-1:0]  rob_num;
  } iq_entry_t;
endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix (older[i][j]=1: entry j is older than entry i) plus an oldest-first grant cascade over the FUs.
// Grants are combinational from req/fu_ready; ordering state updates on allocate/free edges.
module iq_age_matrix #(
  parameter int RS_DEPTH = 16,
  parameter int NUM_FU   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic [RS_DEPTH-1:0]              alloc,
  input  logic [RS_DEPTH-1:0]              free,
  input  logic [RS_DEPTH-1:0]              valid,
  input  logic [RS_DEPTH-1:0]              req,
  input  logic [NUM_FU-1:0]                fu_ready,
  output logic [NUM_FU-1:0][RS_DEPTH-1:0]  grant
);
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older;
  logic [RS_DEPTH-1:0]               avail;

  function automatic logic [RS_DEPTH-1:0] oldest_of(
    input logic [RS_DEPTH-1:0]               mask,
    input logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age
  );
    logic [RS_DEPTH-1:0] oh;
    oh = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      oh[i] = mask[i] && ((age[i] & mask) == '0);
    return oh;
  endfunction

  // A newly allocated entry is younger than every entry that survives this edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      older <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++)
        for (int j = 0; j < RS_DEPTH; j++)
          if (alloc[i])
            older[i][j] <= valid[j] && !free[j];
          else if (free[j])
            older[i][j] <= 1'b0;
    end
  end

  always_comb begin
    avail = req;
    grant = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (fu_ready[f]) begin
        grant[f] = oldest_of(avail, older);
        avail    = avail & ~grant[f];
      end
    end
  end
endmodule

// File: rtl/issue_queue.sv
// Issue queue: holds renamed uops, snoops wakeups, issues up to NUM_FU oldest ready uops per edge (dispatch-to-issue >= 1 edge).
// dispatch_ready drops when full; IQ_WAKEUP_BYPASS_EN selects 0-cycle (defined) or 1-cycle wakeup-to-issue.
module issue_queue
  import iq_pkg::*;
#(
  parameter int  RS_DEPTH   = IQ_RS_DEPTH,
  parameter int  NUM_FU     = IQ_NUM_FU,
  parameter int  NUM_WAKEUP = IQ_NUM_WAKEUP,
  localparam int CNT_W      = $clog2(RS_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [TAG_W-1:0]             disp_rd_tag,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic                         disp_rs1_rdy,
  input  logic [DATA_W-1:0]            disp_rs1_val,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic                         disp_rs2_rdy,
  input  logic [DATA_W-1:0]            disp_rs2_val,
  input  logic [DATA_W-1:0]            disp_imm,
  input  logic [OP_W-1:0]              disp_alu_op,
  input  logic                         disp_is_ls,
  input  logic                         disp_alusrc,
  input  logic [ROB_W-1:0]             disp_rob_num,
  input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
  input  logic [NUM_WAKEUP*TAG_W-1:0]  wakeup_tag,
  input  logic [NUM_WAKEUP*DATA_W-1:0] wakeup_val,
  input  logic [NUM_FU-1:0]            fu_ready,
  output logic [NUM_FU-1:0]            issue_valid,
  output logic [NUM_FU*TAG_W-1:0]      issue_rd_tag,
  output logic [NUM_FU*DATA_W-1:0]     issue_rs1_val,
  output logic [NUM_FU*DATA_W-1:0]     issue_rs2_val,
  output logic [NUM_FU*DATA_W-1:0]     issue_imm,
  output logic [NUM_FU*OP_W-1:0]       issue_alu_op,
  output logic [NUM_FU-1:0]            issue_is_ls,
  output logic [NUM_FU-1:0]            issue_alusrc,
  output logic [NUM_FU*ROB_W-1:0]      issue_rob_num,
  output logic [CNT_W-1:0]             count
);
  iq_entry_t                       ent [RS_DEPTH];
  iq_entry_t                       new_ent;
  logic [RS_DEPTH-1:0]             valid_vec, eligible, alloc, free_vec;
  logic [RS_DEPTH-1:0][DATA_W:0]   m1, m2;
  logic [DATA_W-1:0]               eff1 [RS_DEPTH];
  logic [DATA_W-1:0]               eff2 [RS_DEPTH];
  logic [NUM_FU-1:0][RS_DEPTH-1:0] grant;
  logic [DATA_W:0]                 cap1, cap2;
  logic [CNT_W-1:0]                n_issue;
  logic                            accept;

  // Returns {hit, value}; the lowest matching port wins.
  function automatic logic [DATA_W:0] wk_match(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int p = NUM_WAKEUP - 1; p >= 0; p--)
      if (wakeup_valid[p] && wakeup_tag[p*TAG_W +: TAG_W] == tag)
        r = {1'b1, wakeup_val[p*DATA_W +: DATA_W]};
    return r;
  endfunction

  assign dispatch_ready = (count < CNT_W'(RS_DEPTH));

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      m1[i]        = wk_match(ent[i].rs1_tag);
      m2[i]        = wk_match(ent[i].rs2_tag);
`ifdef IQ_WAKEUP_BYPASS_EN
      eligible[i]  = ent[i].valid && (ent[i].rs1_rdy || m1[i][DATA_W]) && (ent[i].rs2_rdy || m2[i][DATA_W]);
      eff1[i]      = ent[i].rs1_rdy ? ent[i].rs1_val : m1[i][DATA_W-1:0];
      eff2[i]      = ent[i].rs2_rdy ? ent[i].rs2_val : m2[i][DATA_W-1:0];
`else
      eligible[i]  = ent[i].valid && ent[i].rs1_rdy && ent[i].rs2_rdy;
      eff1[i]      = ent[i].rs1_val;
      eff2[i]      = ent[i].rs2_val;
`endif
    end
  end

  always_comb begin
    accept = dispatch_valid && dispatch_ready && !flush;
    alloc  = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        alloc    = '0;
        alloc[i] = 1'b1;
      end
    end
    if (!accept) alloc = '0;
  end

  // Sources woken by a broadcast in the dispatch cycle are captured as ready.
  always_comb begin
    cap1            = wk_match(disp_rs1_tag);
    cap2            = wk_match(disp_rs2_tag);
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.is_ls   = disp_is_ls;
    new_ent.alusrc  = disp_alusrc;
    new_ent.alu_op  = disp_alu_op;
    new_ent.rd_tag  = disp_rd_tag;
    new_ent.rs1_tag = disp_rs1_tag;
    new_ent.rs1_rdy = disp_rs1_rdy || cap1[DATA_W];
    new_ent.rs1_val = (!disp_rs1_rdy && cap1[DATA_W]) ? cap1[DATA_W-1:0] : disp_rs1_val;
    new_ent.rs2_tag = disp_rs2_tag;
    new_ent.rs2_rdy = disp_rs2_rdy || cap2[DATA_W];
    new_ent.rs2_val = (!disp_rs2_rdy && cap2[DATA_W]) ? cap2[DATA_W-1:0] : disp_rs2_val;
    new_ent.imm     = disp_imm;
    new_ent.rob_num = disp_rob_num;
  end

  always_comb begin
    free_vec = '0;
    n_issue  = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      free_vec = free_vec | grant[f];
      n_issue  = n_issue + CNT_W'(grant[f] != '0);
    end
  end

  iq_age_matrix #(
    .RS_DEPTH (RS_DEPTH),
    .NUM_FU   (NUM_FU)
  ) u_age (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .alloc    (alloc),
    .free     (free_vec),
    .valid    (valid_vec),
    .req      (eligible),
    .fu_ready (fu_ready),
    .grant    (grant)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (alloc[i]) begin
          ent[i] <= new_ent;
        end else if (free_vec[i]) begin
          ent[i].valid <= 1'b0;
        end else if (ent[i].valid) begin
          if (!ent[i].rs1_rdy && m1[i][DATA_W]) begin
            ent[i].rs1_rdy <= 1'b1;
            ent[i].rs1_val <= m1[i][DATA_W-1:0];
          end
          if (!ent[i].rs2_rdy && m2[i][DATA_W]) begin
            ent[i].rs2_rdy <= 1'b1;
            ent[i].rs2_val <= m2[i][DATA_W-1:0];
          end
        end
      end
    end
  end

  // Bundle fields of an idle FU hold their last value; only reset zeroes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      issue_valid   <= '0;
      issue_rd_tag  <= '0;
      issue_rs1_val <= '0;
      issue_rs2_val <= '0;
      issue_imm     <= '0;
      issue_alu_op  <= '0;
      issue_is_ls   <= '0;
      issue_alusrc  <= '0;
      issue_rob_num <= '0;
    end else if (flush) begin
      count       <= '0;
      issue_valid <= '0;
    end else begin
      count <= count + CNT_W'(accept) - n_issue;
      for (int f = 0; f < NUM_FU; f++) begin
        issue_valid[f] <= (grant[f] != '0);
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (grant[f][i]) begin
            issue_rd_tag[f*TAG_W +: TAG_W]    <= ent[i].rd_tag;
            issue_rs1_val[f*DATA_W +: DATA_W] <= eff1[i];
            issue_rs2_val[f*DATA_W +: DATA_W] <= eff2[i];
            issue_imm[f*DATA_W +: DATA_W]     <= ent[i].imm;
            issue_alu_op[f*OP_W +: OP_W]      <= ent[i].alu_op;
            issue_is_ls[f]                    <= ent[i].is_ls;
            issue_alusrc[f]                   <= ent[i].alusrc;
            issue_rob_num[f*ROB_W +: ROB_W]   <= ent[i].rob_num;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: age-ordered queue model checked every cycle, plus directed scenarios with literal expectations.
module tb_issue_queue;
  import iq_pkg::*;

  localparam int RS_DEPTH   = 16;
  localparam int NUM_FU     = 3;
  localparam int NUM_WAKEUP = 4;
  localparam int CNT_W      = $clog2(RS_DEPTH + 1);

  logic                         clk = 1'b0;
  logic                         reset, flush, dispatch_valid, dispatch_ready;
  logic [TAG_W-1:0]             disp_rd_tag, disp_rs1_tag, disp_rs2_tag;
  logic                         disp_rs1_rdy, disp_rs2_rdy, disp_is_ls, disp_alusrc;
  logic [DATA_W-1:0]            disp_rs1_val, disp_rs2_val, disp_imm;
  logic [OP_W-1:0]              disp_alu_op;
  logic [ROB_W-1:0]             disp_rob_num;
  logic [NUM_WAKEUP-1:0]        wakeup_valid;
  logic [NUM_WAKEUP*TAG_W-1:0]  wakeup_tag;
  logic [NUM_WAKEUP*DATA_W-1:0] wakeup_val;
  logic [NUM_FU-1:0]            fu_ready, issue_valid, issue_is_ls, issue_alusrc;
  logic [NUM_FU*TAG_W-1:0]      issue_rd_tag;
  logic [NUM_FU*DATA_W-1:0]     issue_rs1_val, issue_rs2_val, issue_imm;
  logic [NUM_FU*OP_W-1:0]       issue_alu_op;
  logic [NUM_FU*ROB_W-1:0]      issue_rob_num;
  logic [CNT_W-1:0]             count;

  issue_queue #(.RS_DEPTH(RS_DEPTH), .NUM_FU(NUM_FU), .NUM_WAKEUP(NUM_WAKEUP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .disp_rd_tag(disp_rd_tag), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_rdy(disp_rs1_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs2_val(disp_rs2_val), .disp_imm(disp_imm), .disp_alu_op(disp_alu_op),
    .disp_is_ls(disp_is_ls), .disp_alusrc(disp_alusrc), .disp_rob_num(disp_rob_num),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag), .wakeup_val(wakeup_val),
    .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_rd_tag(issue_rd_tag),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val), .issue_imm(issue_imm),
    .issue_alu_op(issue_alu_op), .issue_is_ls(issue_is_ls), .issue_alusrc(issue_alusrc),
    .issue_rob_num(issue_rob_num), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  t1;
    logic              r1;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  t2;
    logic              r2;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [OP_W-1:0]   op;
    logic              ls;
    logic              asrc;
    logic [ROB_W-1:0]  rob;
  } m_ent_t;

  m_ent_t            mq[$];
  m_ent_t            nq[$];
  m_ent_t            m_bund [NUM_FU];
  logic [NUM_FU-1:0] m_iv;
  bit                tk [RS_DEPTH];
  int                n_checks = 0;
  int                n_errors = 0;
  bit                chk_en   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit wk(input logic [TAG_W-1:0] tag, output logic [DATA_W-1:0] v);
    v = '0;
    for (int p = 0; p < NUM_WAKEUP; p++)
      if (wakeup_valid[p] && wakeup_tag[p*TAG_W +: TAG_W] == tag) begin
        v = wakeup_val[p*DATA_W +: DATA_W];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // Readiness as seen by select this edge; with bypass a same-cycle broadcast counts.
  function automatic bit elig(input m_ent_t e, output m_ent_t o);
    logic [DATA_W-1:0] v;
    o = e;
`ifdef IQ_WAKEUP_BYPASS_EN
    if (!o.r1 && wk(o.t1, v)) begin o.r1 = 1'b1; o.v1 = v; end
    if (!o.r2 && wk(o.t2, v)) begin o.r2 = 1'b1; o.v2 = v; end
`endif
    return o.r1 && o.r2;
  endfunction

  // Model: mq is kept oldest-first, so select is a front-to-back scan.
  always @(posedge clk) begin
    m_ent_t e, o;
    logic [DATA_W-1:0] v;
    bit done;
    int n_before;
    if (reset) begin
      mq.delete();
      m_iv = '0;
      for (int f = 0; f < NUM_FU; f++) m_bund[f] = '0;
    end else if (flush) begin
      mq.delete();
      m_iv = '0;
    end else begin
      n_before = mq.size();
      m_iv = '0;
      for (int k = 0; k < RS_DEPTH; k++) tk[k] = 1'b0;
      for (int f = 0; f < NUM_FU; f++) begin
        if (fu_ready[f]) begin
          done = 1'b0;
          for (int k = 0; k < mq.size(); k++)
            if (!done && !tk[k] && elig(mq[k], o)) begin
              tk[k] = 1'b1; done = 1'b1; m_iv[f] = 1'b1; m_bund[f] = o;
            end
        end
      end
      nq.delete();
      for (int k = 0; k < mq.size(); k++) begin
        if (!tk[k]) begin
          e = mq[k];
          if (!e.r1 && wk(e.t1, v)) begin e.r1 = 1'b1; e.v1 = v; end
          if (!e.r2 && wk(e.t2, v)) begin e.r2 = 1'b1; e.v2 = v; end
          nq.push_back(e);
        end
      end
      if (dispatch_valid && n_before < RS_DEPTH) begin
        e = '{rd: disp_rd_tag, t1: disp_rs1_tag, r1: disp_rs1_rdy, v1: disp_rs1_val,
              t2: disp_rs2_tag, r2: disp_rs2_rdy, v2: disp_rs2_val, imm: disp_imm,
              op: disp_alu_op, ls: disp_is_ls, asrc: disp_alusrc, rob: disp_rob_num};
        if (!e.r1 && wk(e.t1, v)) begin e.r1 = 1'b1; e.v1 = v; end
        if (!e.r2 && wk(e.t2, v)) begin e.r2 = 1'b1; e.v2 = v; end
        nq.push_back(e);
      end
      mq = nq;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("dispatch_ready", 64'(dispatch_ready), 64'(mq.size() < RS_DEPTH));
      for (int f = 0; f < NUM_FU; f++) begin
        chk($sformatf("issue_valid[%0d]", f), 64'(issue_valid[f]), 64'(m_iv[f]));
        chk($sformatf("rd_tag[%0d]", f), 64'(issue_rd_tag[f*TAG_W +: TAG_W]), 64'(m_bund[f].rd));
        chk($sformatf("rs1_val[%0d]", f), 64'(issue_rs1_val[f*DATA_W +: DATA_W]), 64'(m_bund[f].v1));
        chk($sformatf("rs2_val[%0d]", f), 64'(issue_rs2_val[f*DATA_W +: DATA_W]), 64'(m_bund[f].v2));
        chk($sformatf("imm[%0d]", f), 64'(issue_imm[f*DATA_W +: DATA_W]), 64'(m_bund[f].imm));
        chk($sformatf("alu_op[%0d]", f), 64'(issue_alu_op[f*OP_W +: OP_W]), 64'(m_bund[f].op));
        chk($sformatf("is_ls[%0d]", f), 64'(issue_is_ls[f]), 64'(m_bund[f].ls));
        chk($sformatf("alusrc[%0d]", f), 64'(issue_alusrc[f]), 64'(m_bund[f].asrc));
        chk($sformatf("rob_num[%0d]", f), 64'(issue_rob_num[f*ROB_W +: ROB_W]), 64'(m_bund[f].rob));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    wakeup_valid   = '0;
    flush          = 1'b0;
  endtask

  task automatic put(input logic [TAG_W-1:0] rd, input logic [TAG_W-1:0] t1, input logic r1,
                     input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] t2, input logic r2,
                     input logic [DATA_W-1:0] v2, input logic [ROB_W-1:0] rob);
    logic [DATA_W-1:0] imm_v;
    imm_v          = 32'h100 + 32'(rd);
    dispatch_valid = 1'b1;
    disp_rd_tag    = rd;
    disp_rs1_tag   = t1; disp_rs1_rdy = r1; disp_rs1_val = v1;
    disp_rs2_tag   = t2; disp_rs2_rdy = r2; disp_rs2_val = v2;
    disp_imm       = imm_v;
    disp_alu_op    = rd[3:0];
    disp_is_ls     = rd[0];
    disp_alusrc    = rd[1];
    disp_rob_num   = rob;
  endtask

  task automatic wake(input int p, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    wakeup_valid[p]                = 1'b1;
    wakeup_tag[p*TAG_W +: TAG_W]   = tag;
    wakeup_val[p*DATA_W +: DATA_W] = val;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; fu_ready = '0;
    disp_rd_tag = '0; disp_rs1_tag = '0; disp_rs1_rdy = 1'b0; disp_rs1_val = '0;
    disp_rs2_tag = '0; disp_rs2_rdy = 1'b0; disp_rs2_val = '0; disp_imm = '0;
    disp_alu_op = '0; disp_is_ls = 1'b0; disp_alusrc = 1'b0; disp_rob_num = '0;
    wakeup_valid = '0; wakeup_tag = '0; wakeup_val = '0;
    step(); step();
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);
    chk("reset_dispatch_ready", 64'(dispatch_ready), 64'd1);
    chk("reset_rs1_val", 64'(issue_rs1_val), 64'd0);

    // 1: ready uop issues one edge after dispatch on FU0
    fu_ready = 3'b111;
    put(6'd5, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22, 6'd3);
    step(); idle();
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_iv_early", 64'(issue_valid), 64'd0);
    step();
    chk("t1_iv", 64'(issue_valid), 64'b001);
    chk("t1_rd", 64'(issue_rd_tag[0 +: TAG_W]), 64'd5);
    chk("t1_rob", 64'(issue_rob_num[0 +: ROB_W]), 64'd3);

    // 2: younger ready uop bypasses older waiting one; wakeup releases the older
    put(6'd10, 6'd9, 1'b0, 32'h0, 6'd2, 1'b1, 32'h22, 6'd4);
    step();
    put(6'd11, 6'd1, 1'b1, 32'h33, 6'd2, 1'b1, 32'h44, 6'd5);
    step(); idle();
    chk("t2_iv_none", 64'(issue_valid), 64'd0);
    step();
    chk("t2_iv_b", 64'(issue_valid), 64'b001);
    chk("t2_rd_b", 64'(issue_rd_tag[0 +: TAG_W]), 64'd11);
    wake(0, 6'd9, 32'hDEAD);
    step(); idle();
`ifdef IQ_WAKEUP_BYPASS_EN
    chk("t2_iv_a", 64'(issue_valid), 64'b001);
`else
    chk("t2_iv_gap", 64'(issue_valid), 64'd0);
    step();
    chk("t2_iv_a", 64'(issue_valid), 64'b001);
`endif
    chk("t2_rd_a", 64'(issue_rd_tag[0 +: TAG_W]), 64'd10);
    chk("t2_rs1_a", 64'(issue_rs1_val[0 +: DATA_W]), 64'hDEAD);
    step();

    // 3: fill to capacity, extra dispatch ignored, then three oldest drain
    fu_ready = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      put(6'(20 + i), 6'd1, 1'b1, 32'(i), 6'd2, 1'b1, 32'(100 + i), 6'(i));
      step();
    end
    chk("t3_full_count", 64'(count), 64'd16);
    chk("t3_full_ready", 64'(dispatch_ready), 64'd0);
    put(6'd63, 6'd1, 1'b1, 32'h5, 6'd2, 1'b1, 32'h6, 6'd63);
    step(); idle();
    chk("t3_extra_count", 64'(count), 64'd16);
    fu_ready = 3'b111;
    step();
    chk("t3_iv", 64'(issue_valid), 64'b111);
    chk("t3_rd0", 64'(issue_rd_tag[0*TAG_W +: TAG_W]), 64'd20);
    chk("t3_rd1", 64'(issue_rd_tag[1*TAG_W +: TAG_W]), 64'd21);
    chk("t3_rd2", 64'(issue_rd_tag[2*TAG_W +: TAG_W]), 64'd22);
    chk("t3_count", 64'(count), 64'd13);
    do_reset();
    chk("t3_rst_count", 64'(count), 64'd0);
    chk("t3_rst_rd", 64'(issue_rd_tag), 64'd0);

    // 4: source captured from a same-cycle broadcast on port 3
    fu_ready = 3'b111;
    put(6'd7, 6'd1, 1'b1, 32'h1, 6'd12, 1'b0, 32'h0, 6'd8);
    wake(3, 6'd12, 32'd7);
    step(); idle();
    chk("t4_count", 64'(count), 64'd1);
    step();
    chk("t4_iv", 64'(issue_valid), 64'b001);
    chk("t4_rs2", 64'(issue_rs2_val[0 +: DATA_W]), 64'd7);

    // 5: FU1 stalled, oldest goes to FU0 and next to FU2; freed slot reuse keeps age
    fu_ready = '0;
    for (int i = 0; i < 4; i++) begin
      put(6'(40 + i), 6'd1, 1'b1, 32'(i), 6'd2, 1'b1, 32'(i), 6'(i));
      step();
    end
    idle();
    fu_ready = 3'b101;
    step();
    chk("t5_iv", 64'(issue_valid), 64'b101);
    chk("t5_rd0", 64'(issue_rd_tag[0*TAG_W +: TAG_W]), 64'd40);
    chk("t5_rd2", 64'(issue_rd_tag[2*TAG_W +: TAG_W]), 64'd41);
    chk("t5_count", 64'(count), 64'd2);
    fu_ready = '0;
    put(6'd44, 6'd1, 1'b1, 32'h9, 6'd2, 1'b1, 32'h9, 6'd9);
    step(); idle();
    fu_ready = 3'b001;
    step();
    chk("t5_reuse_rd", 64'(issue_rd_tag[0 +: TAG_W]), 64'd42);
    chk("t5_reuse_count", 64'(count), 64'd2);

    // 6: flush drops everything, including that cycle's dispatch
    do_reset();
    fu_ready = '0;
    for (int i = 0; i < 5; i++) begin
      put(6'(50 + i), 6'd1, 1'b1, 32'(i), 6'd2, 1'b1, 32'(i), 6'(i));
      step();
    end
    idle();
    chk("t6_count5", 64'(count), 64'd5);
    flush    = 1'b1;
    fu_ready = 3'b111;
    put(6'd60, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h1, 6'd1);
    step(); idle();
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_iv", 64'(issue_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_stale", 64'(issue_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
